adc_therm_decode: RTL

Thermometer-to-binary decoder on the receive side of the row/column thermometer interface. It samples two asynchronous 15-bit thermometer buses (row and column comparator banks), bubble-corrects them, and converts them back to an 8-bit code {row, col}. It averages 2^AVG_LOG2 consecutive samples per conversion and returns the result over a valid/ready handshake. It sits between the mixed-signal comparator array and the digital readout/loopback logic.

---
 rtl/adc_therm_pkg.sv | 23 ++
 rtl/adc_therm_correct.sv | 31 +++
 rtl/adc_therm_decode.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/adc_therm_pkg.sv
// Shared widths, FSM encoding and popcount helper for the thermometer decoder.
package adc_therm_pkg;

    localparam int THERM_W = 15;
    localparam int NIB_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        ACCUM,
        OUTPUT
    } state_e;

    function automatic logic [NIB_W-1:0] popcount15(input logic [THERM_W-1:0] v);
        logic [NIB_W-1:0] n;
        n = '0;
        for (int i = 0; i < THERM_W; i++) begin
            n = n + NIB_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/adc_therm_correct.sv
// One comparator bank: 3-tap majority bubble filter, popcount and residual
// non-thermometer detection. Purely combinational.
module adc_therm_correct
    import adc_therm_pkg::*;
(
    input  logic [THERM_W-1:0] therm_i,
    output logic [NIB_W-1:0]   count_o,
    output logic               err_o
);

    logic [THERM_W+1:0] ext;
    logic [THERM_W-1:0] corr;
    logic [THERM_W:0]   corr_inc;

    // Virtual neighbours: a 1 below bit 0 and a 0 above bit 14.
    assign ext = {1'b0, therm_i, 1'b1};

    always_comb begin
        // NOTE: assigning a default before the loop keeps every bit driven on every path, so no latch is inferred.
        corr = '0;
        for (int i = 0; i < THERM_W; i++) begin
            corr[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
    end

    // A clean thermometer is 2^n-1, so c & (c+1) is zero exactly when no 1 sits above a 0.
    assign corr_inc = {1'b0, corr} + (THERM_W+1)'(1);
    assign err_o    = |({1'b0, corr} & corr_inc);
    assign count_o  = popcount15(corr);

endmodule

// File: rtl/adc_therm_decode.sv
// Receive-side thermometer decoder: synchronize, bubble-correct, average
// 2^AVG_LOG2 samples and hand the rounded {row, col} code out on valid/ready.
module adc_therm_decode
    import adc_therm_pkg::*;
#(
    parameter int AVG_LOG2    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [THERM_W-1:0] ROWS_IN,
    input  logic [THERM_W-1:0] COLS_IN,
    input  logic               START,
    output logic               BUSY,
    output logic               DOUT_VALID,
    input  logic               DOUT_READY,
    output logic [7:0]         DOUT,
    output logic               CODE_ERR
);

    localparam int CODE_W = 2 * NIB_W;
    localparam int ACC_W  = CODE_W + AVG_LOG2;
    localparam int CNT_W  = 5;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] ACCUM_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [ACC_W-1:0] ROUND_HALF  = ACC_W'((1 << AVG_LOG2) >> 1);

    logic [2*THERM_W-1:0] sync_q [SYNC_STAGES];
    logic [NIB_W-1:0]     row_cnt, col_cnt;
    logic                 row_err, col_err;
    logic [CODE_W-1:0]    code_q;
    logic                 serr_q;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic                 acc_err_q, acc_err_d;
    logic [7:0]           dout_q, dout_d;
    logic                 err_q, err_d;
    logic                 valid_q, valid_d;

    // NOTE: the synchronizer array is reset explicitly because its contents are observable state, not scratch memory.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= {ROWS_IN, COLS_IN};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    adc_therm_correct u_row_correct (
        .therm_i (sync_q[SYNC_STAGES-1][2*THERM_W-1:THERM_W]),
        .count_o (row_cnt),
        .err_o   (row_err)
    );

    adc_therm_correct u_col_correct (
        .therm_i (sync_q[SYNC_STAGES-1][THERM_W-1:0]),
        .count_o (col_cnt),
        .err_o   (col_err)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            code_q <= '0;
            serr_q <= 1'b0;
        end else begin
            code_q <= {row_cnt, col_cnt};
            serr_q <= row_err | col_err;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (START) state_d = SETTLE;
            SETTLE:  if (cnt_q == SETTLE_LAST) state_d = ACCUM;
            ACCUM:   if (cnt_q == ACCUM_LAST) state_d = OUTPUT;
            OUTPUT:  if (valid_q && DOUT_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // OUTPUT spends one cycle loading the rounded result before VALID rises.
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        acc_err_d = acc_err_q;
        dout_d    = dout_q;
        err_d     = err_q;
        valid_d   = valid_q;
        case (state_q)
            IDLE: cnt_d = '0;
            SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d     = '0;
                    acc_d     = '0;
                    acc_err_d = 1'b0;
                end
            end
            ACCUM: begin
                cnt_d     = cnt_q + CNT_W'(1);
                acc_d     = acc_q + ACC_W'(code_q);
                acc_err_d = acc_err_q | serr_q;
            end
            OUTPUT: begin
                cnt_d = '0;
                if (!valid_q) begin
                    dout_d  = 8'((acc_q + ROUND_HALF) >> AVG_LOG2);
                    err_d   = acc_err_q;
                    valid_d = 1'b1;
                end else if (DOUT_READY) begin
                    valid_d = 1'b0;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            acc_err_q <= 1'b0;
            dout_q    <= '0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            acc_err_q <= acc_err_d;
            dout_q    <= dout_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        BUSY       = (state_q != IDLE);
        DOUT_VALID = valid_q;
        DOUT       = dout_q;
        CODE_ERR   = err_q;
    end

endmodule
